// File: rtl/ts_packet_framer_if.sv
// ts_packet_framer_if: payload input handshake and transport byte output
// bundle for the TS packetiser. The framer uses the slave modport; the
// payload source / channel side uses the master modport.
interface ts_packet_framer_if;
    logic       byte_en;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       pusi;
    logic [7:0] byte_out;
    logic       valid;
    logic       sync;
    logic       pkt_done;
    logic [3:0] cc;

    modport master (
        output byte_en, data_in, data_valid, pusi,
        input  data_ready, byte_out, valid, sync, pkt_done, cc
    );

    modport slave (
        input  byte_en, data_in, data_valid, pusi,
        output data_ready, byte_out, valid, sync, pkt_done, cc
    );
endinterface

// File: rtl/ts_packet_framer.sv
// ts_packet_framer: transmit-side MPEG-2 TS packetiser. Emits 188-byte
// packets (4-byte header with sync 0x47, PID 0x100 and continuity counter,
// then 184 payload bytes), one byte per byte_en slot, registered outputs.
// Optional build macro NULL_STUFFING_EN: idle slots start a null packet
// (PID 0x1FFF) so the output carries a byte on every slot.
module ts_packet_framer (
    input  logic               clk,
    input  logic               rst,
    ts_packet_framer_if.slave  bus
);
    localparam logic [12:0] PID      = 13'h100;
    localparam logic [7:0]  SYNC     = 8'h47;
    localparam logic [7:0]  LAST_IDX = 8'd187;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD
`ifdef NULL_STUFFING_EN
        , NULLPKT
`endif
    } state_t;

    state_t     state, state_n;
    logic [7:0] idx, idx_n;
    logic [3:0] cc_q, cc_n;
    logic       pusi_l, pusi_n;
    logic [7:0] byte_q, byte_n;
    logic       valid_q, valid_n;
    logic       sync_q, sync_n;
    logic       done_q, done_n;

    assign bus.data_ready = bus.byte_en & (state == PAYLOAD);
    assign bus.byte_out   = byte_q;
    assign bus.valid      = valid_q;
    assign bus.sync       = sync_q;
    assign bus.pkt_done   = done_q;
    assign bus.cc         = cc_q;

    // State, byte index, counter and registered output stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            idx     <= '0;
            cc_q    <= '0;
            pusi_l  <= 1'b0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            sync_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            cc_q    <= cc_n;
            pusi_l  <= pusi_n;
            byte_q  <= byte_n;
            valid_q <= valid_n;
            sync_q  <= sync_n;
            done_q  <= done_n;
        end
    end

    // Next-state and next-byte decision, taken only on byte_en slots
    always_comb begin
        state_n = state;
        idx_n   = idx;
        cc_n    = cc_q;
        pusi_n  = pusi_l;
        byte_n  = byte_q;
        valid_n = 1'b0;
        sync_n  = 1'b0;
        done_n  = 1'b0;
        if (bus.byte_en) begin
            case (state)
                IDLE: begin
                    // data_in is not consumed here; the header goes first
                    if (bus.data_valid) begin
                        byte_n  = SYNC;
                        valid_n = 1'b1;
                        sync_n  = 1'b1;
                        pusi_n  = bus.pusi;
                        idx_n   = 8'd1;
                        state_n = HEADER;
                    end
`ifdef NULL_STUFFING_EN
                    else begin
                        byte_n  = SYNC;
                        valid_n = 1'b1;
                        sync_n  = 1'b1;
                        idx_n   = 8'd1;
                        state_n = NULLPKT;
                    end
`endif
                end
                HEADER: begin
                    valid_n = 1'b1;
                    case (idx)
                        8'd1:    byte_n = {1'b0, pusi_l, 1'b0, PID[12:8]};
                        8'd2:    byte_n = PID[7:0];
                        default: byte_n = {4'b0001, cc_q};
                    endcase
                    idx_n = idx + 8'd1;
                    if (idx == 8'd3) state_n = PAYLOAD;
                end
                PAYLOAD: begin
                    // underflow stalls the packet; nothing is padded
                    if (bus.data_valid) begin
                        byte_n  = bus.data_in;
                        valid_n = 1'b1;
                        if (idx == LAST_IDX) begin
                            done_n  = 1'b1;
                            cc_n    = cc_q + 4'd1;
                            idx_n   = '0;
                            state_n = IDLE;
                        end else begin
                            idx_n = idx + 8'd1;
                        end
                    end
                end
`ifdef NULL_STUFFING_EN
                NULLPKT: begin
                    valid_n = 1'b1;
                    case (idx)
                        8'd1:    byte_n = 8'h1F;
                        8'd2:    byte_n = 8'hFF;
                        8'd3:    byte_n = 8'h10;
                        default: byte_n = 8'hFF;
                    endcase
                    if (idx == LAST_IDX) begin
                        done_n  = 1'b1;
                        idx_n   = '0;
                        state_n = IDLE;
                    end else begin
                        idx_n = idx + 8'd1;
                    end
                end
`endif
                default: state_n = IDLE;
            endcase
        end
    end
endmodule

// File: doc/ts_packet_framer.md
# ts_packet_framer

Transmit-side MPEG-2 TS packetiser. It takes a raw payload byte stream through a valid/ready handshake and emits 188-byte transport packets, one byte per output slot. Each packet is a 4-byte header (sync 0x47, fixed PID, continuity counter) followed by 184 payload bytes. It sits ahead of the channel and produces exactly the byte/valid/sync stream the receive-side sync recovery expects. Optional null-packet stuffing keeps the output rate constant when no payload is available.

## Interface
- PID, 13'h100, PID inserted in every data packet.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- byte_en  in  1  output byte slot strobe; at most one byte is emitted per cycle with byte_en=1.
- data_in  in  8  payload byte.
- data_valid  in  1  data_in is valid.
- data_ready  out  1  combinational: byte_en & (state==PAYLOAD); the byte transfers when data_ready & data_valid.
- pusi  in  1  payload_unit_start_indicator; sampled when a data packet starts.
- byte_out  out  8  transmitted byte (registered).
- valid  out  1  byte_out is valid this cycle (registered).
- sync  out  1  high with byte 0 (0x47) of every packet.
- pkt_done  out  1  high with byte 187 of every packet.
- cc  out  4  continuity counter of the next data packet.

## Operation
- **State machine**
  - States: IDLE, HEADER, PAYLOAD, NULLPKT.
  - Byte index idx is 8 bits, range 0..187.
  - All transitions occur only on cycles with byte_en=1.
- **IDLE**
  - data_valid=1: emit 0x47 with sync=1, latch pusi, set idx=1, go to HEADER. data_in is not consumed here.
  - Else, if stuffing is compiled in: emit 0x47 with sync=1, set idx=1, go to NULLPKT.
  - Otherwise: valid=0.
- **HEADER** (emitted unconditionally, one per slot, independent of data_valid)
  - idx1 = {1'b0, pusi_l, 1'b0, PID[12:8]}.
  - idx2 = PID[7:0].
  - idx3 = {2'b00, 2'b01, cc}.
  - After idx3, go to PAYLOAD with idx=4.
- **PAYLOAD** (idx 4..187)
  - Handshake: data_valid=1 emits data_in and increments idx.
  - Underflow: data_valid=0 gives valid=0 and idx holds. The packet stalls and is never padded.
  - On idx 187 transfer: pkt_done=1, cc <= cc+1 (mod 16, 15 wraps to 0), go to IDLE.
- **NULLPKT**
  - Bytes: 0x47, 0x1F, 0xFF, 0x10, then 0xFF ×184.
  - Never asserts data_ready. Does not advance cc. pkt_done pulses on byte 187.
  - A data_valid that rises mid-packet waits until the null packet completes.
- **Back-to-back packets:** the IDLE decision is taken in the slot immediately after byte 187. A continuously fed stream therefore produces packets with no gap slots.
- **Reset values:** byte_out=0x00, valid=0, sync=0, pkt_done=0, cc=0, state=IDLE, idx=0.
- **Reset mid-packet:** the partial packet is aborted. The next packet starts with 0x47 and cc=0.

## Timing
- Latency: a byte decided in a cycle N with byte_en=1 appears on byte_out/valid/sync/pkt_done at N+1.
- Cycle with byte_en=0: next cycle has valid=0, sync=0, pkt_done=0; byte_out holds its value.
- data_ready is combinational from byte_en and state. No combinational path exists from data_valid to any output except through the registers.
- Minimum packet duration is 188 byte_en slots. Each packet carries exactly 188 valid bytes, separated by an arbitrary number of valid=0 cycles.

## Configuration
- NULL_STUFFING_EN defined: an IDLE slot with data_valid=0 starts a null packet (PID 0x1FFF), so valid=1 on every byte_en slot.
- Not defined: the NULLPKT state is absent, and IDLE with data_valid=0 outputs valid=0.

## Test plan
- **Reset:** assert rst=0 mid-operation.
  - Required: all outputs at their reset values within the same cycle.
  - Required after release: the first packet begins with 0x47 and cc=0.
- **Continuous feed** (byte_en=1, data_valid=1, pusi=1, PID=0x100):
  - Packet 1 required: 0x47 (sync=1), 0x41, 0x00, 0x10, then data_in bytes.
  - Packet 1 required: pkt_done on byte 187.
  - Packet 2 required: next 0x47 exactly 188 cycles after the first; its byte 3 is 0x11.
- **Sparse byte_en:** byte_en every other cycle.
  - Required: valid only in the cycle after each slot.
  - Required: one packet spans 376 cycles.
- **Underflow:** drop data_valid for 5 slots at idx 100.
  - Required: valid=0 for those slots, no 0xFF padding, payload order preserved.
  - Required: the packet still totals 188 valid bytes.
- **Stuffing:** data_valid=0 with NULL_STUFFING_EN defined.
  - Required: 0x47, 0x1F, 0xFF, 0x10, then 0xFF ×184, repeating.
  - Required: data_ready never high and cc unchanged.
  - Without the macro: valid stays 0.
- **CC wrap:** send 17 packets.
  - Required: byte 3 sequence 0x10..0x1F, then 0x10.
